// File: rtl/uart_axis_rx.sv
// UART 8N1 receiver feeding an AXI-Stream byte source through a small elastic FIFO.
// Define UART_RX_IDLE_TLAST_EN to force tlast on the last queued byte after a long idle line.
module uart_axis_rx #(
  parameter int         BAUD_DIV   = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] EOL_CHAR   = 8'h0A,
  parameter int         IDLE_BITS  = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int CNT_W  = $clog2(BAUD_DIV);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Out-of-range parameters leave this marker block in the elaborated hierarchy.
  if (BAUD_DIV < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      IDLE_BITS < 1) begin : g_illegal_params
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta, rx_s;
  logic             push, frame_err_d, start_det;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, pop, push_ok, drop;
  logic [8:0]       head;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Every sample point is reached when the bit-time counter runs out; START waits half a bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    start_det   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          start_det = 1'b1;
          cnt_d     = HALF_LOAD;
          state_d   = START;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          cnt_d     = FULL_LOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop     = o_tvalid & i_tready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

`ifdef UART_RX_IDLE_TLAST_EN
  localparam int IDLE_CYCLES = IDLE_BITS * BAUD_DIV;
  localparam int IDLE_W      = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_armed;
  logic [PTR_W-1:0]  last_ptr, last_ofs, occupancy;
  logic              last_in_fifo, force_tlast;

  // The last pushed entry is still queued when its offset from the read pointer is below the occupancy.
  assign last_ofs     = last_ptr - rd_ptr;
  assign occupancy    = wr_ptr - rd_ptr;
  assign last_in_fifo = (last_ofs < occupancy);
  assign force_tlast  = idle_armed && (state_q == IDLE) && !start_det &&
                        (idle_cnt == IDLE_LAST) && last_in_fifo &&
                        !(pop && (rd_ptr == last_ptr));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt   <= '0;
      idle_armed <= 1'b0;
      last_ptr   <= '0;
    end else begin
      if (push) begin
        idle_cnt   <= '0;
        idle_armed <= 1'b1;
      end else if (start_det) begin
        idle_cnt   <= '0;
        idle_armed <= 1'b0;
      end else if (idle_armed) begin
        if (idle_cnt == IDLE_LAST) begin
          idle_armed <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
      if (push_ok) begin
        last_ptr <= wr_ptr;
      end
    end
  end
`endif

  // Storage carries no reset; o_tvalid gates what reaches the outputs.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {(shift_q == EOL_CHAR), shift_q};
    end
`ifdef UART_RX_IDLE_TLAST_EN
    if (force_tlast) begin
      mem[last_ptr[ADDR_W-1:0]][8] <= 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      o_frame_err <= frame_err_d;
      o_overflow  <= drop;
    end
  end

  assign head     = mem[rd_ptr[ADDR_W-1:0]];
  assign o_tvalid = ~empty;
  assign o_tdata  = o_tvalid ? head[7:0] : 8'h00;
  assign o_tlast  = o_tvalid & head[8];

endmodule

// File: tb/tb_uart_axis_rx.sv
// Directed bench for uart_axis_rx: serial frames in, AXIS beats checked against a queue model.
module tb_uart_axis_rx;

  localparam int         BAUD_DIV   = 16;
  localparam int         FIFO_DEPTH = 16;
  localparam logic [7:0] EOL_CHAR   = 8'h0A;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tready = 1'b0;
  logic [7:0] o_tdata;
  logic       o_tlast, o_tvalid, o_frame_err, o_overflow;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int ferr_seen = 0, ovf_seen = 0, exp_ferr = 0, exp_ovf = 0;
  int beats_seen = 0, last_beat_cyc = 0, start_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_last = 1'b0;
  beat_t      exp_q[$];

  always #5 clk = ~clk;

  uart_axis_rx #(
    .BAUD_DIV  (BAUD_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .EOL_CHAR  (EOL_CHAR),
    .IDLE_BITS (20)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_uart_rx  (rx),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .i_tready   (tready),
    .o_frame_err(o_frame_err),
    .o_overflow (o_overflow)
  );

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A correctly framed byte joins the expected stream unless the FIFO already holds FIFO_DEPTH entries.
  task automatic model_push(input logic [7:0] b);
    beat_t e;
    if (exp_q.size() >= FIFO_DEPTH) begin
      exp_ovf++;
    end else begin
      e.data = b;
      e.last = (b == EOL_CHAR);
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit, input int extra_low_bits);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (BAUD_DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD_DIV) tick();
    end
    rx = stop_bit;
    if (stop_bit) model_push(b);
    else exp_ferr++;
    repeat (BAUD_DIV * (1 + extra_low_bits)) tick();
    rx = 1'b1;
    repeat (BAUD_DIV) tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || o_tvalid) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) $display("[TB] FAIL %s timeout: still pending after %0d cycles", name, n);
    check_output({name, "_pending"}, exp_q.size(), 0);
    check_output({name, "_tvalid"}, {31'd0, o_tvalid}, 0);
  endtask

  // Head of the model queue must match the outputs on every valid cycle; stability comes for free.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_frame_err) ferr_seen++;
      if (o_overflow) ovf_seen++;
      if (o_tvalid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_beat: got tdata=%02h tlast=%0b, required no beat",
                   o_tdata, o_tlast);
        end else begin
          check_output("beat_tdata", {24'd0, o_tdata}, {24'd0, exp_q[0].data});
          check_output("beat_tlast", {31'd0, o_tlast}, {31'd0, exp_q[0].last});
          if (tready) begin
            last_data     = o_tdata;
            last_last     = o_tlast;
            last_beat_cyc = cyc;
            beats_seen++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    repeat (3) tick();
    check_output("rst_tvalid", {31'd0, o_tvalid}, 0);
    check_output("rst_tlast", {31'd0, o_tlast}, 0);
    check_output("rst_tdata", {24'd0, o_tdata}, 0);
    check_output("rst_frame_err", {31'd0, o_frame_err}, 0);
    check_output("rst_overflow", {31'd0, o_overflow}, 0);
    rst_n = 1'b1;

    repeat (2000) tick();
    check_output("idle_frame_err_count", ferr_seen, 0);
    check_output("idle_overflow_count", ovf_seen, 0);
    check_output("idle_tvalid", {31'd0, o_tvalid}, 0);

    tready = 1'b1;
    apply_stimulus(8'h55, 1'b1, 0);
    wait_drain("byte55");
    lat = last_beat_cyc - start_cyc;
    check_output("byte55_latency_max", {31'd0, lat <= BAUD_DIV * 10 + 4}, 1);
    check_output("byte55_latency_min", {31'd0, lat >= BAUD_DIV * 9}, 1);
    check_output("byte55_data", {24'd0, last_data}, 32'h55);
    check_output("byte55_tlast", {31'd0, last_last}, 0);
    check_output("byte55_count", beats_seen, 1);

    apply_stimulus(8'h41, 1'b1, 0);
    apply_stimulus(8'h0A, 1'b1, 0);
    wait_drain("eol");
    check_output("eol_data", {24'd0, last_data}, 32'h0A);
    check_output("eol_tlast", {31'd0, last_last}, 1);
    check_output("eol_count", beats_seen, 3);

    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    check_output("glitch_frame_err_count", ferr_seen, 0);
    check_output("glitch_count", beats_seen, 3);
    check_output("glitch_tvalid", {31'd0, o_tvalid}, 0);

    apply_stimulus(8'h3C, 1'b0, 2);
    repeat (2 * BAUD_DIV) tick();
    check_output("framing_err_pulses", ferr_seen, 1);
    check_output("framing_no_beat", beats_seen, 3);
    apply_stimulus(8'h33, 1'b1, 0);
    wait_drain("after_break");
    check_output("after_break_data", {24'd0, last_data}, 32'h33);
    check_output("after_break_count", beats_seen, 4);

    tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(8'(i), 1'b1, 0);
    end
    check_output("fill_no_overflow", ovf_seen, 0);
    check_output("fill_tvalid", {31'd0, o_tvalid}, 1);
    apply_stimulus(8'h10, 1'b1, 0);
    check_output("overflow_pulses", ovf_seen, 1);
    check_output("overflow_model", ovf_seen, exp_ovf);
    tready = 1'b1;
    wait_drain("overflow_drain");
    check_output("overflow_last_data", {24'd0, last_data}, 32'h0F);
    check_output("overflow_count", beats_seen, 20);
    check_output("final_frame_err_model", ferr_seen, exp_ferr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
